ipe_init_loader: RTL and testbench
==================================

# ipe_init_loader

Boot-time sequencer that programs the IPE peripheral (MPUIPC0, MPUIPSEGB2, MPUIPSEGB1) from a non-volatile init structure before the CPU fetches its first instruction. It holds the CPU after every PUC and reads the IPE signature and init structure through a program-memory read port. It validates the structure and writes it into the IPE registers over a private peripheral-bus master port, which the top level muxes ahead of the CPU. Locking MPUIPC0 last guarantees software never sees an unlocked, partially configured IPE.

## Interface
Parameters:
- SIG_ADDR, 16'hFF88, byte address of IPE signature word; the pointer word is at SIG_ADDR+2
- SIG_VALUE, 16'hAAAA, signature value that enables loading
- PTR_MIN, 16'hC000, lowest legal init-structure address
- PTR_MAX, 16'hFF80, structure must end at or below this; last legal pointer is PTR_MAX-8
- IPE_BASE, 15'h05A8, IPE peripheral byte base; IPC0 at +2, SEGB2 at +4, SEGB1 at +6

Ports:
- mclk  in  1  main clock
- puc_rst  in  1  reset; asynchronous, active-high
- ldr_mem_req  out  1  program-memory read strobe
- ldr_mem_addr  out  16  byte address of the read
- ldr_mem_dout  in  16  read data, valid the cycle after ldr_mem_req
- ldr_per_en  out  1  peripheral access enable
- ldr_per_addr  out  14  peripheral word address (byte address >> 1)
- ldr_per_din  out  16  peripheral write data
- ldr_per_we  out  2  write enables; always 2'b11 when ldr_per_en=1
- ldr_cpu_hold  out  1  stalls CPU fetch while loading
- ldr_done  out  1  sticky, high once the sequence has ended
- ldr_status  out  2  00 busy, 01 loaded, 10 no signature, 11 invalid structure
- ldr_err_nmi  out  1  one-cycle pulse on status 11

## Operation
- Reset values: ldr_cpu_hold=1; all other outputs 0; FSM in SIG_REQ.
- FSM states: SIG_REQ, SIG_CAP, PTR_REQ, PTR_CAP, then REQ/CAP pairs for IPC0, SEGB2, SEGB1 and CHK, followed by CHECK, WR_SEGB2, WR_SEGB1, WR_IPC0, FIN.
- REQ states: drive ldr_mem_req=1 and ldr_mem_addr. CAP states: register ldr_mem_dout.
- Structure words are read at ptr, ptr+2, ptr+4, ptr+6, in the order IPC0, SEGB2, SEGB1, CHK.
- SIG_CAP: if data ≠ SIG_VALUE, go to FIN with status 10 and perform no IPE writes.
- PTR_CAP: the pointer is invalid if any of these holds: bit0 set, ptr < PTR_MIN, ptr > PTR_MAX-8 (compare in 17 bits, no wrap). An invalid pointer goes to FIN with status 11.
- CHECK: the structure is valid only if both hold:
  - CHK == ~(IPC0 ^ SEGB2 ^ SEGB1)
  - SEGB1[12:0] < SEGB2[12:0] (unsigned)
- CHECK invalid: go to FIN with status 11. CHECK valid: go to WR_SEGB2.
- Write order is SEGB2, then SEGB1, then IPC0. IPC0 is written last because its lock bit blocks later writes.
- ldr_per_din values:
  - SEGB writes: {3'b0, value[12:0]}
  - IPC0 write: IPC0 | 16'h0080 (lock forced); bit 6 is passed through unchanged.
- FIN: set ldr_done=1 and ldr_status. Status 01 is set only after the WR_IPC0 cycle.
- ldr_err_nmi pulses for the single cycle of FIN entry when status is 11.
- ldr_cpu_hold drops to 0 on FIN entry. FIN is absorbing until the next puc_rst.
- puc_rst at any point, including mid-write, asynchronously returns all state to reset values. The sequence restarts after release. A write interrupted by reset is not re-issued partially.

## Timing
- Cycle n = nth rising mclk edge after puc_rst deasserts. State SIG_REQ is active during cycle 1.
- Each memory word costs 2 cycles (REQ, CAP); there is no back-to-back pipelining.
- Valid path:
  - 12 read cycles, then CHECK in cycle 13
  - writes in cycles 14–16, one per cycle, with ldr_per_en high for exactly 1 cycle each
  - FIN in cycle 17
- No-signature path: FIN in cycle 3.
- Bad-pointer path: FIN in cycle 5.
- Bad-check path: FIN in cycle 14.
- ldr_mem_req and ldr_per_en are never high in the same cycle.

## Structure
- Shared defines file holds:
  - IPE register byte offsets (IPC0 2, SEGB2 4, SEGB1 6)
  - lock bit index 7
  - SIG_VALUE
  - the status encodings 00/01/10/11
- ipe_periph and this block both use these defines.
- One combinational sub-module, ipe_init_check: takes the four captured words and produces check_ok.
- The FSM, capture registers and bus drivers stay in ipe_init_loader.

## Test plan
- Valid load, done high and hold low at cycle 17:
  - stimulus: sig=AAAA, ptr=FF00; IPC0=0040, SEGB2=0C80, SEGB1=0C40, CHK=FF7F
  - required writes, in order: per_addr 2D6←0C80, 2D7←0C40, 2D5←00C0
  - required result: status 01
- No signature: sig=FFFF → reads stop after the signature word; no ldr_per_en; status 10; hold low at cycle 3.
- Bad checksum: same as the valid load but CHK=FF7E → no writes; ldr_err_nmi one pulse at cycle 14; status 11.
- Bad segments: SEGB1=0C80, SEGB2=0C40 with a matching checksum → status 11; no writes.
- Bad pointer, each → FIN at cycle 5 with status 11:
  - ptr=FF01 (odd)
  - ptr=BFFE (below PTR_MIN)
  - ptr=FF7A (beyond PTR_MAX-8)
- Reset mid-operation: assert puc_rst during WR_SEGB1 (cycle 15) → all outputs reset immediately; after release the full valid sequence replays, finishing at cycle 17.

Source files
------------

// File: rtl/ipe_init_loader_pkg.sv
// Shared IPE definitions: register offsets, lock bit, signature, loader status codes and FSM states.
package ipe_init_loader_pkg;

    localparam logic [15:0] IPE_OFS_IPC0  = 16'd2;
    localparam logic [15:0] IPE_OFS_SEGB2 = 16'd4;
    localparam logic [15:0] IPE_OFS_SEGB1 = 16'd6;
    localparam int unsigned IPE_LOCK_BIT  = 7;
    localparam logic [15:0] IPE_SIG_VALUE = 16'hAAAA;

    typedef enum logic [1:0] {
        LDR_ST_BUSY    = 2'b00,
        LDR_ST_LOADED  = 2'b01,
        LDR_ST_NOSIG   = 2'b10,
        LDR_ST_INVALID = 2'b11
    } ldr_status_e;

    typedef enum logic [4:0] {
        SIG_REQ   = 5'd0,
        SIG_CAP   = 5'd1,
        PTR_REQ   = 5'd2,
        PTR_CAP   = 5'd3,
        IPC0_REQ  = 5'd4,
        IPC0_CAP  = 5'd5,
        SEGB2_REQ = 5'd6,
        SEGB2_CAP = 5'd7,
        SEGB1_REQ = 5'd8,
        SEGB1_CAP = 5'd9,
        CHK_REQ   = 5'd10,
        CHK_CAP   = 5'd11,
        CHECK     = 5'd12,
        WR_SEGB2  = 5'd13,
        WR_SEGB1  = 5'd14,
        WR_IPC0   = 5'd15,
        FIN       = 5'd16
    } ldr_state_e;

    // Peripheral word address of an IPE register.
    function automatic logic [13:0] ipe_word_addr(input logic [14:0] base, input logic [15:0] ofs);
        return 14'(({1'b0, base} + ofs) >> 1);
    endfunction

    // Structure must be word aligned and fit entirely in [pmin, pmax]; 17-bit compare avoids wrap.
    function automatic logic ptr_is_valid(input logic [15:0] ptr, input logic [15:0] pmin,
                                          input logic [15:0] pmax);
        logic [16:0] p17;
        p17 = {1'b0, ptr};
        return (ptr[0] == 1'b0) && (p17 >= {1'b0, pmin}) && (p17 <= ({1'b0, pmax} - 17'd8));
    endfunction

endpackage

// File: rtl/ipe_init_loader_if.sv
// Loader bus: program-memory read port plus private peripheral-bus master port.
interface ipe_init_loader_if;
    logic        ldr_mem_req;
    logic [15:0] ldr_mem_addr;
    logic [15:0] ldr_mem_dout;
    logic        ldr_per_en;
    logic [13:0] ldr_per_addr;
    logic [15:0] ldr_per_din;
    logic [1:0]  ldr_per_we;

    modport master (
        output ldr_mem_req, ldr_mem_addr,
        input  ldr_mem_dout,
        output ldr_per_en, ldr_per_addr, ldr_per_din, ldr_per_we
    );

    modport slave (
        input  ldr_mem_req, ldr_mem_addr,
        output ldr_mem_dout,
        input  ldr_per_en, ldr_per_addr, ldr_per_din, ldr_per_we
    );
endinterface

// File: rtl/ipe_init_check.sv
// Combinational validation of a captured IPE init structure.
module ipe_init_check (
    input  logic [15:0] ipc0_i,
    input  logic [15:0] segb2_i,
    input  logic [15:0] segb1_i,
    input  logic [15:0] chk_i,
    output logic        check_ok_o
);
    logic sum_ok_s;
    logic seg_ok_s;

    assign sum_ok_s   = (chk_i == ~(ipc0_i ^ segb2_i ^ segb1_i));
    assign seg_ok_s   = (segb1_i[12:0] < segb2_i[12:0]);
    assign check_ok_o = sum_ok_s & seg_ok_s;
endmodule

// File: rtl/ipe_init_loader.sv
// Boot sequencer: reads the IPE init structure after every PUC and programs the IPE registers, IPC0 last.
module ipe_init_loader
    import ipe_init_loader_pkg::*;
#(
    parameter logic [15:0] SIG_ADDR  = 16'hFF88,
    parameter logic [15:0] SIG_VALUE = IPE_SIG_VALUE,
    parameter logic [15:0] PTR_MIN   = 16'hC000,
    parameter logic [15:0] PTR_MAX   = 16'hFF80,
    parameter logic [14:0] IPE_BASE  = 15'h05A8
) (
    input  logic                      mclk,
    input  logic                      puc_rst,
    ipe_init_loader_if.master         bus,
    output logic                      ldr_cpu_hold,
    output logic                      ldr_done,
    output logic [1:0]                ldr_status,
    output logic                      ldr_err_nmi
);
    ldr_state_e  state_q, state_d;
    ldr_status_e status_q, status_d;
    logic [15:0] ptr_q, ipc0_q, segb2_q, segb1_q, chk_q;
    logic        done_q, hold_q, nmi_q;
    logic        per_en_q, per_en_d;
    logic [13:0] per_addr_q, per_addr_d;
    logic [15:0] per_din_q, per_din_d;
    logic [1:0]  per_we_q;
    logic        req_s;
    logic [15:0] addr_s;
    logic        check_ok_s;

    ipe_init_check u_check (
        .ipc0_i     (ipc0_q),
        .segb2_i    (segb2_q),
        .segb1_i    (segb1_q),
        .chk_i      (chk_q),
        .check_ok_o (check_ok_s)
    );

    // Next-state and completion status
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            SIG_REQ:   state_d = SIG_CAP;
            SIG_CAP: begin
                if (bus.ldr_mem_dout != SIG_VALUE) begin
                    state_d  = FIN;
                    status_d = LDR_ST_NOSIG;
                end else begin
                    state_d = PTR_REQ;
                end
            end
            PTR_REQ:   state_d = PTR_CAP;
            PTR_CAP: begin
                if (!ptr_is_valid(bus.ldr_mem_dout, PTR_MIN, PTR_MAX)) begin
                    state_d  = FIN;
                    status_d = LDR_ST_INVALID;
                end else begin
                    state_d = IPC0_REQ;
                end
            end
            IPC0_REQ:  state_d = IPC0_CAP;
            IPC0_CAP:  state_d = SEGB2_REQ;
            SEGB2_REQ: state_d = SEGB2_CAP;
            SEGB2_CAP: state_d = SEGB1_REQ;
            SEGB1_REQ: state_d = SEGB1_CAP;
            SEGB1_CAP: state_d = CHK_REQ;
            CHK_REQ:   state_d = CHK_CAP;
            CHK_CAP:   state_d = CHECK;
            CHECK: begin
                if (check_ok_s) begin
                    state_d = WR_SEGB2;
                end else begin
                    state_d  = FIN;
                    status_d = LDR_ST_INVALID;
                end
            end
            WR_SEGB2:  state_d = WR_SEGB1;
            WR_SEGB1:  state_d = WR_IPC0;
            WR_IPC0: begin
                state_d  = FIN;
                status_d = LDR_ST_LOADED;
            end
            FIN:       state_d = FIN;
            default:   state_d = SIG_REQ;
        endcase
    end

    // Program-memory read port, decoded from the current state
    always_comb begin
        req_s  = 1'b0;
        addr_s = 16'h0000;
        case (state_q)
            SIG_REQ:   begin req_s = 1'b1; addr_s = SIG_ADDR;          end
            PTR_REQ:   begin req_s = 1'b1; addr_s = SIG_ADDR + 16'd2;  end
            IPC0_REQ:  begin req_s = 1'b1; addr_s = ptr_q;             end
            SEGB2_REQ: begin req_s = 1'b1; addr_s = ptr_q + 16'd2;     end
            SEGB1_REQ: begin req_s = 1'b1; addr_s = ptr_q + 16'd4;     end
            CHK_REQ:   begin req_s = 1'b1; addr_s = ptr_q + 16'd6;     end
            default:   begin req_s = 1'b0; addr_s = 16'h0000;          end
        endcase
    end

    assign bus.ldr_mem_req  = req_s & ~puc_rst;
    assign bus.ldr_mem_addr = puc_rst ? 16'h0000 : addr_s;

    // Peripheral write for the state being entered, so the bus is registered
    always_comb begin
        per_en_d   = 1'b0;
        per_addr_d = 14'h0000;
        per_din_d  = 16'h0000;
        case (state_d)
            WR_SEGB2: begin
                per_en_d   = 1'b1;
                per_addr_d = ipe_word_addr(IPE_BASE, IPE_OFS_SEGB2);
                per_din_d  = {3'b000, segb2_q[12:0]};
            end
            WR_SEGB1: begin
                per_en_d   = 1'b1;
                per_addr_d = ipe_word_addr(IPE_BASE, IPE_OFS_SEGB1);
                per_din_d  = {3'b000, segb1_q[12:0]};
            end
            WR_IPC0: begin
                per_en_d   = 1'b1;
                per_addr_d = ipe_word_addr(IPE_BASE, IPE_OFS_IPC0);
                per_din_d  = ipc0_q | (16'h0001 << IPE_LOCK_BIT);
            end
            default: begin
                per_en_d   = 1'b0;
                per_addr_d = 14'h0000;
                per_din_d  = 16'h0000;
            end
        endcase
    end

    // State, capture and output registers
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q    <= SIG_REQ;
            status_q   <= LDR_ST_BUSY;
            ptr_q      <= 16'h0000;
            ipc0_q     <= 16'h0000;
            segb2_q    <= 16'h0000;
            segb1_q    <= 16'h0000;
            chk_q      <= 16'h0000;
            done_q     <= 1'b0;
            hold_q     <= 1'b1;
            nmi_q      <= 1'b0;
            per_en_q   <= 1'b0;
            per_addr_q <= 14'h0000;
            per_din_q  <= 16'h0000;
            per_we_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            per_en_q   <= per_en_d;
            per_addr_q <= per_addr_d;
            per_din_q  <= per_din_d;
            per_we_q   <= per_en_d ? 2'b11 : 2'b00;
            nmi_q      <= (state_d == FIN) && (state_q != FIN) && (status_d == LDR_ST_INVALID);
            if (state_d == FIN) begin
                done_q <= 1'b1;
                hold_q <= 1'b0;
            end
            case (state_q)
                PTR_CAP:   ptr_q   <= bus.ldr_mem_dout;
                IPC0_CAP:  ipc0_q  <= bus.ldr_mem_dout;
                SEGB2_CAP: segb2_q <= bus.ldr_mem_dout;
                SEGB1_CAP: segb1_q <= bus.ldr_mem_dout;
                CHK_CAP:   chk_q   <= bus.ldr_mem_dout;
                default:   ;
            endcase
        end
    end

    assign bus.ldr_per_en   = per_en_q;
    assign bus.ldr_per_addr = per_addr_q;
    assign bus.ldr_per_din  = per_din_q;
    assign bus.ldr_per_we   = per_we_q;
    assign ldr_cpu_hold     = hold_q;
    assign ldr_done         = done_q;
    assign ldr_status       = status_q;
    assign ldr_err_nmi      = nmi_q;

endmodule

// File: tb/tb_ipe_init_loader.sv
// Directed table-driven bench for ipe_init_loader with a small program-memory model.
module tb_ipe_init_loader;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        ldr_cpu_hold;
    logic        ldr_done;
    logic [1:0]  ldr_status;
    logic        ldr_err_nmi;

    ipe_init_loader_if bus ();

    ipe_init_loader dut (
        .mclk         (mclk),
        .puc_rst      (puc_rst),
        .bus          (bus.master),
        .ldr_cpu_hold (ldr_cpu_hold),
        .ldr_done     (ldr_done),
        .ldr_status   (ldr_status),
        .ldr_err_nmi  (ldr_err_nmi)
    );

    always #5 mclk = ~mclk;

    logic [15:0] m_sig, m_ptr, m_ipc0, m_segb2, m_segb1, m_chk;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (a == 16'hFF88)              return m_sig;
        else if (a == 16'hFF8A)         return m_ptr;
        else if (a == m_ptr)            return m_ipc0;
        else if (a == m_ptr + 16'd2)    return m_segb2;
        else if (a == m_ptr + 16'd4)    return m_segb1;
        else if (a == m_ptr + 16'd6)    return m_chk;
        else                            return 16'hDEAD;
    endfunction

    initial bus.ldr_mem_dout = 16'h0000;
    always @(posedge mclk) begin
        if (bus.ldr_mem_req) bus.ldr_mem_dout <= mem_rd(bus.ldr_mem_addr);
    end

    typedef struct {
        string       name;
        logic [15:0] sig, ptr, ipc0, segb2, segb1, chk;
        logic [1:0]  st;
        int          fin;
        int          nrd;
        int          nwr;
    } vec_t;

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Applies one vector; abort_cyc>0 asserts puc_rst in that cycle instead of finishing.
    task automatic run_vec(input vec_t v, input int abort_cyc);
        int cyc, fin_cyc, nrd, nwr, nmi_n, nmi_cyc, hold_err, ovl, we_err;
        logic [15:0] rd_addr [8];
        logic [13:0] wr_addr [4];
        logic [15:0] wr_din  [4];
        int          wr_cyc  [4];
        logic [15:0] exp_rd  [6];
        logic [13:0] exp_wa  [3];
        logic [15:0] exp_wd  [3];
        m_sig = v.sig; m_ptr = v.ptr; m_ipc0 = v.ipc0;
        m_segb2 = v.segb2; m_segb1 = v.segb1; m_chk = v.chk;
        puc_rst = 1'b1;
        @(posedge mclk); @(posedge mclk); #1;
        check({v.name, " rst hold"},   {31'd0, ldr_cpu_hold}, 32'd1);
        check({v.name, " rst out"},
              {26'd0, ldr_done, ldr_status, ldr_err_nmi, bus.ldr_mem_req, bus.ldr_per_en}, 32'd0);
        puc_rst = 1'b0;
        cyc = 1; fin_cyc = 0; nrd = 0; nwr = 0; nmi_n = 0; nmi_cyc = 0;
        hold_err = 0; ovl = 0; we_err = 0;
        for (int i = 0; i < 8; i++) rd_addr[i] = 16'h0;
        for (int i = 0; i < 4; i++) begin wr_addr[i] = 14'h0; wr_din[i] = 16'h0; wr_cyc[i] = 0; end
        for (int k = 0; k < 40; k++) begin
            @(negedge mclk);
            if (abort_cyc > 0 && cyc == abort_cyc) begin
                check({v.name, " per_en before abort"}, {31'd0, bus.ldr_per_en}, 32'd1);
                puc_rst = 1'b1;
                #1;
                check({v.name, " abort hold"}, {31'd0, ldr_cpu_hold}, 32'd1);
                check({v.name, " abort out"},
                      {26'd0, ldr_done, ldr_status, ldr_err_nmi, bus.ldr_mem_req, bus.ldr_per_en}, 32'd0);
                return;
            end
            if (ldr_done && fin_cyc == 0) fin_cyc = cyc;
            if (!ldr_done && !ldr_cpu_hold) hold_err++;
            if (bus.ldr_mem_req && bus.ldr_per_en) ovl++;
            if (bus.ldr_mem_req) begin
                if (nrd < 8) rd_addr[nrd] = bus.ldr_mem_addr;
                nrd++;
            end
            if (bus.ldr_per_en) begin
                if (bus.ldr_per_we !== 2'b11) we_err++;
                if (nwr < 4) begin
                    wr_addr[nwr] = bus.ldr_per_addr; wr_din[nwr] = bus.ldr_per_din; wr_cyc[nwr] = cyc;
                end
                nwr++;
            end
            if (ldr_err_nmi) begin nmi_n++; nmi_cyc = cyc; end
            @(posedge mclk); #1;
            cyc++;
        end
        check({v.name, " fin cycle"}, fin_cyc, v.fin);
        check({v.name, " status"},    {30'd0, ldr_status}, {30'd0, v.st});
        check({v.name, " done/hold"}, {30'd0, ldr_done, ldr_cpu_hold}, 32'd2);
        check({v.name, " early hold drop"}, hold_err, 0);
        check({v.name, " req/en overlap"},  ovl, 0);
        check({v.name, " per_we"},          we_err, 0);
        check({v.name, " reads"},  nrd, v.nrd);
        check({v.name, " writes"}, nwr, v.nwr);
        check({v.name, " nmi pulses"}, nmi_n, (v.st == 2'b11) ? 1 : 0);
        if (v.st == 2'b11) check({v.name, " nmi cycle"}, nmi_cyc, v.fin);
        exp_rd[0] = 16'hFF88; exp_rd[1] = 16'hFF8A;
        exp_rd[2] = v.ptr; exp_rd[3] = v.ptr + 16'd2; exp_rd[4] = v.ptr + 16'd4; exp_rd[5] = v.ptr + 16'd6;
        for (int i = 0; i < v.nrd; i++) check({v.name, " read addr"}, {16'd0, rd_addr[i]}, {16'd0, exp_rd[i]});
        exp_wa[0] = 14'h2D6; exp_wd[0] = {3'b000, v.segb2[12:0]};
        exp_wa[1] = 14'h2D7; exp_wd[1] = {3'b000, v.segb1[12:0]};
        exp_wa[2] = 14'h2D5; exp_wd[2] = v.ipc0 | 16'h0080;
        for (int i = 0; i < v.nwr; i++) begin
            check({v.name, " wr addr"},  {18'd0, wr_addr[i]}, {18'd0, exp_wa[i]});
            check({v.name, " wr data"},  {16'd0, wr_din[i]},  {16'd0, exp_wd[i]});
            check({v.name, " wr cycle"}, wr_cyc[i], 14 + i);
        end
    endtask

    vec_t vecs [10];

    initial begin
        //          name        sig       ptr       ipc0      segb2     segb1     chk       st     fin rd wr
        vecs[0] = '{"valid",    16'hAAAA, 16'hFF00, 16'h0040, 16'h0C80, 16'h0C40, 16'hFF7F, 2'b01, 17, 6, 3};
        vecs[1] = '{"nosig",    16'hFFFF, 16'hFF00, 16'h0040, 16'h0C80, 16'h0C40, 16'hFF7F, 2'b10, 3,  1, 0};
        vecs[2] = '{"badchk",   16'hAAAA, 16'hFF00, 16'h0040, 16'h0C80, 16'h0C40, 16'hFF7E, 2'b11, 14, 6, 0};
        vecs[3] = '{"badseg",   16'hAAAA, 16'hFF00, 16'h0040, 16'h0C40, 16'h0C80, 16'hFF7F, 2'b11, 14, 6, 0};
        vecs[4] = '{"eqseg",    16'hAAAA, 16'hFF00, 16'h0040, 16'h0C80, 16'h0C80, 16'hFFBF, 2'b11, 14, 6, 0};
        vecs[5] = '{"ptr_odd",  16'hAAAA, 16'hFF01, 16'h0040, 16'h0C80, 16'h0C40, 16'hFF7F, 2'b11, 5,  2, 0};
        vecs[6] = '{"ptr_low",  16'hAAAA, 16'hBFFE, 16'h0040, 16'h0C80, 16'h0C40, 16'hFF7F, 2'b11, 5,  2, 0};
        vecs[7] = '{"ptr_high", 16'hAAAA, 16'hFF7A, 16'h0040, 16'h0C80, 16'h0C40, 16'hFF7F, 2'b11, 5,  2, 0};
        vecs[8] = '{"ptr_last", 16'hAAAA, 16'hFF78, 16'h0040, 16'h0C80, 16'h0C40, 16'hFF7F, 2'b01, 17, 6, 3};
        vecs[9] = '{"ptr_min",  16'hAAAA, 16'hC000, 16'h0000, 16'hE123, 16'h0100, 16'h1FDC, 2'b01, 17, 6, 3};

        for (int i = 0; i < 10; i++) run_vec(vecs[i], 0);

        // Reset during WR_SEGB1, then the full valid sequence must replay.
        run_vec(vecs[0], 15);
        run_vec(vecs[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
